wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Shares the single register-file write port between the
//                writeback stage and a multi-cycle unit (MDU). MDU results
//                are queued in a 2-entry FIFO. Pipe writes have priority,
//                and a starvation counter briefly stalls the pipe so that a
//                queued MDU result can drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_v,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_v,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_r,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    // Counter wide enough to hold STARVE_LIMIT itself.
    localparam int             SW           = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  c_starve_max = SW'(STARVE_LIMIT);

    // FIFO state: two entries, 1-bit pointers that wrap naturally.
    logic [1:0]  r_count;
    logic        r_wptr;
    logic        r_rptr;
    logic [4:0]  r_mem_addr [0:1];
    logic [31:0] r_mem_data [0:1];

    logic [SW-1:0] r_starve;
    logic          r_stall;
    logic          r_we;
    logic [4:0]    r_addr;
    logic [31:0]   r_data;

    logic          w_pipe_req;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_data;
    logic [SW-1:0] w_starve_inc;

    // A zero destination is a store/branch: it never claims the write port.
    assign w_pipe_req   = pipe_v & (pipe_addr != 5'd0);
    assign w_nonempty   = (r_count != 2'd0);
    assign mdu_r        = (r_count < 2'd2);
    assign w_push       = mdu_v & mdu_r;
    // Pop is evaluated on the registered count, so a fresh push is never
    // popped in the same cycle (no bypass path).
    assign w_pop        = ~w_pipe_req & w_nonempty;
    assign w_head_addr  = r_mem_addr[r_rptr];
    assign w_head_data  = r_mem_data[r_rptr];
    assign w_starve_inc = r_starve + 1'b1;

    assign pipe_stall = r_stall;
    assign rf_we      = r_we;
    assign rf_addr    = r_addr;
    assign rf_data    = r_data;

    // FIFO storage: contents need no reset, occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= mdu_addr;
            r_mem_data[r_wptr] <= mdu_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation tracking: a one-cycle stall pulse once the head has waited
    // STARVE_LIMIT cycles behind pipe traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else if (!w_nonempty || w_pop) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else if (w_starve_inc == c_starve_max) begin
            r_starve <= '0;
            r_stall  <= 1'b1;
        end else begin
            r_starve <= w_starve_inc;
            r_stall  <= 1'b0;
        end
    end

    // Registered write port: pipe first, then FIFO head; address/data hold
    // whenever nothing is written (including a discarded zero-address pop).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= 5'd0;
            r_data <= 32'd0;
        end else if (w_pipe_req) begin
            r_we   <= 1'b1;
            r_addr <= pipe_addr;
            r_data <= pipe_data;
        end else if (w_pop && (w_head_addr != 5'd0)) begin
            r_we   <= 1'b1;
            r_addr <= w_head_addr;
            r_data <= w_head_data;
        end else begin
            r_we   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: table vectors, directed
//                multi-cycle sequences and randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_v;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        mdu_v;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_r;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_v(pipe_v), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .pipe_stall(pipe_stall),
        .mdu_v(mdu_v), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_r(mdu_r),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of pending MDU results plus expected outputs.
    logic [36:0] mq [$];
    int          m_wait;
    logic        m_we, m_stall;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  wlog [$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_wait  = 0;
        m_we    = 1'b0;
        m_stall = 1'b0;
        m_addr  = 5'd0;
        m_data  = 32'd0;
    endfunction

    // One clock: predict from current inputs, clock, then compare outputs.
    task automatic cycle(output bit accepted);
        bit          preq, pop;
        logic [36:0] head;
        preq = pipe_v && (pipe_addr != 5'd0);
        pop  = !preq && (mq.size() > 0);
        chk("mdu_r", 32'(mdu_r), 32'(mq.size() < 2));
        accepted = mdu_v && (mq.size() < 2);
        m_we = 1'b0;
        if (preq) begin
            m_we = 1'b1; m_addr = pipe_addr; m_data = pipe_data;
        end else if (pop) begin
            head = mq[0];
            if (head[36:32] != 5'd0) begin
                m_we = 1'b1; m_addr = head[36:32]; m_data = head[31:0];
            end
        end
        m_stall = 1'b0;
        if (pop || mq.size() == 0) m_wait = 0;
        else begin
            m_wait++;
            if (m_wait == LIMIT) begin m_stall = 1'b1; m_wait = 0; end
        end
        if (pop) void'(mq.pop_front());
        if (accepted) mq.push_back({mdu_addr, mdu_data});
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_addr", 32'(rf_addr), 32'(m_addr));
        chk("rf_data", rf_data, m_data);
        chk("pipe_stall", 32'(pipe_stall), 32'(m_stall));
        if (rf_we) wlog.push_back(rf_addr);
    endtask

    typedef struct {
        logic        pv; logic [4:0] pa; logic [31:0] pd;
        logic        mv; logic [4:0] ma; logic [31:0] md;
        logic        we; logic [4:0] a;  logic [31:0] d;
        logic        st; logic       mr;
    } vec_t;

    vec_t tbl [9];
    bit   acc;
    int   idx;
    logic [4:0]  off_a [3];
    logic [31:0] off_d [3];

    initial begin
        // Fixed vectors starting right after reset release.
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 5'd0, 32'h99,       1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h11,       1'b0, 1'b1};
        tbl[4] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd8, 32'h88, 1'b1, 5'd3, 32'h33,       1'b0, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88,       1'b0, 1'b1};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99,       1'b0, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 5'd9, 32'h99,       1'b0, 1'b1};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 32'h99,       1'b0, 1'b1};

        rst = 1'b1; pipe_v = 0; pipe_addr = 0; pipe_data = 0;
        mdu_v = 0; mdu_addr = 0; mdu_data = 0;
        model_reset();
        #12;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_addr", 32'(rf_addr), 32'd0);
        chk("reset_rf_data", rf_data, 32'd0);
        chk("reset_stall", 32'(pipe_stall), 32'd0);
        chk("reset_mdu_r", 32'(mdu_r), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            pipe_v = tbl[i].pv; pipe_addr = tbl[i].pa; pipe_data = tbl[i].pd;
            mdu_v  = tbl[i].mv; mdu_addr  = tbl[i].ma; mdu_data  = tbl[i].md;
            cycle(acc);
            chk($sformatf("tbl%0d_we", i),    32'(rf_we),      32'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i),  32'(rf_addr),    32'(tbl[i].a));
            chk($sformatf("tbl%0d_data", i),  rf_data,         tbl[i].d);
            chk($sformatf("tbl%0d_stall", i), 32'(pipe_stall), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_mdu_r", i), 32'(mdu_r),      32'(tbl[i].mr));
        end
        mdu_v = 0; pipe_v = 0;

        // Back-pressure with continuous pipe traffic, stall honoured.
        off_a[0] = 5'd10; off_a[1] = 5'd11; off_a[2] = 5'd12;
        off_d[0] = 32'h1; off_d[1] = 32'h2; off_d[2] = 32'h3;
        wlog.delete();
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            pipe_v = !pipe_stall; pipe_addr = 5'd1; pipe_data = 32'(c);
            mdu_v = (idx < 3);
            mdu_addr = (idx < 3) ? off_a[idx] : 5'd0;
            mdu_data = (idx < 3) ? off_d[idx] : 32'd0;
            cycle(acc);
            if (acc) begin
                idx++;
                if (idx == 2) chk("bp_mdu_r_after_two", 32'(mdu_r), 32'd0);
            end
        end
        chk("bp_all_accepted", 32'(idx), 32'd3);
        begin
            logic [4:0] got [$];
            foreach (wlog[k]) if (wlog[k] >= 5'd10) got.push_back(wlog[k]);
            chk("bp_count", 32'(got.size()), 32'd3);
            for (int k = 0; k < 3; k++)
                chk($sformatf("bp_order%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(off_a[k]));
        end
        pipe_v = 0; mdu_v = 0;
        for (int c = 0; c < 3; c++) cycle(acc);

        // Starvation: one entry behind continuous pipe requests.
        pipe_v = 1; pipe_addr = 5'd2; pipe_data = 32'hA0;
        mdu_v = 1; mdu_addr = 5'd7; mdu_data = 32'h77;
        cycle(acc);
        chk("st_push", 32'(acc), 32'd1);
        mdu_v = 0;
        for (int c = 1; c <= 3; c++) begin
            pipe_data = 32'hA0 + 32'(c);
            cycle(acc);
            chk($sformatf("st_wait%0d", c), 32'(pipe_stall), 32'd0);
        end
        pipe_data = 32'hA4;
        cycle(acc);
        chk("st_stall_high", 32'(pipe_stall), 32'd1);
        chk("st_pipe_wr", 32'(rf_addr), 32'd2);
        pipe_v = 0;
        cycle(acc);
        chk("st_stall_low", 32'(pipe_stall), 32'd0);
        chk("st_mdu_we", 32'(rf_we), 32'd1);
        chk("st_mdu_addr", 32'(rf_addr), 32'd7);
        chk("st_mdu_data", rf_data, 32'h77);

        // Reset with two entries queued.
        pipe_v = 1; pipe_addr = 5'd3; pipe_data = 32'hB0;
        mdu_v = 1; mdu_addr = 5'd20; mdu_data = 32'h20;
        cycle(acc);
        mdu_addr = 5'd21; mdu_data = 32'h21;
        cycle(acc);
        chk("rs_full", 32'(mdu_r), 32'd0);
        mdu_v = 0; pipe_v = 0;
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("rs_rf_we", 32'(rf_we), 32'd0);
        chk("rs_rf_addr", 32'(rf_addr), 32'd0);
        chk("rs_rf_data", rf_data, 32'd0);
        chk("rs_stall", 32'(pipe_stall), 32'd0);
        chk("rs_mdu_r", 32'(mdu_r), 32'd1);
        @(posedge clk); #1;
        chk("rs_hold_we", 32'(rf_we), 32'd0);
        rst = 1'b0;
        wlog.delete();
        for (int c = 0; c < 5; c++) cycle(acc);
        chk("rs_no_stale", 32'(wlog.size()), 32'd0);

        // Randomized traffic; the MDU holds its offer until accepted.
        mdu_v = 0;
        for (int c = 0; c < 1500; c++) begin
            pipe_v    = ($urandom_range(0, 3) != 0) && !pipe_stall;
            pipe_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data = $urandom;
            if (!mdu_v && ($urandom_range(0, 2) == 0)) begin
                mdu_v    = 1'b1;
                mdu_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdu_data = $urandom;
            end
            cycle(acc);
            if (acc) mdu_v = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
